// File: rtl/z_mux_arbiter_if.sv
// z_mux_arbiter_if: request/done inputs and sel/grant outputs shared by the mux arbiter and its two requesters
interface z_mux_arbiter_if;
  logic req_a;
  logic req_b;
  logic done_a;
  logic done_b;
  logic sel;
  logic gnt_a;
  logic gnt_b;
  logic busy;
  modport master (input req_a, req_b, done_a, done_b, output sel, gnt_a, gnt_b, busy);
  modport slave (output req_a, req_b, done_a, done_b, input sel, gnt_a, gnt_b, busy);
endinterface

// File: rtl/z_mux_arbiter.sv
// z_mux_arbiter: round-robin owner of the 2:1 mux select with a hold limit against starvation
// Define Z_MUX_ARB_TURNAROUND_EN to insert one dead TURN cycle on every A<->B handover.
module z_mux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic reset_,
  z_mux_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
`ifdef Z_MUX_ARB_TURNAROUND_EN
    , TURN
`endif
  } state_t;
`ifdef Z_MUX_ARB_TURNAROUND_EN
  localparam state_t HAND_A = TURN;
  localparam state_t HAND_B = TURN;
`else
  localparam state_t HAND_A = OWN_A;
  localparam state_t HAND_B = OWN_B;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic sel_q, sel_d, gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d, busy_q, busy_d;
  logic sat, rel_a, rel_b;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      sel_q <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      sel_q <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q <= busy_d;
    end
  end
  // last_q: 0 = A owned last, 1 = B owned last
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    sat = cnt_q == CNT_MAX;
    rel_a = bus.done_a || !bus.req_a || (sat && bus.req_b);
    rel_b = bus.done_b || !bus.req_b || (sat && bus.req_a);
    case (state_q)
      IDLE: state_d = (bus.req_a && (!bus.req_b || last_q)) ? OWN_A : bus.req_b ? OWN_B : IDLE;
      OWN_A: begin
        cnt_d = rel_a ? '0 : sat ? cnt_q : cnt_q + 1'b1;
        last_d = rel_a ? 1'b0 : last_q;
        state_d = !rel_a ? OWN_A : bus.req_b ? HAND_B : IDLE;
      end
      OWN_B: begin
        cnt_d = rel_b ? '0 : sat ? cnt_q : cnt_q + 1'b1;
        last_d = rel_b ? 1'b1 : last_q;
        state_d = !rel_b ? OWN_B : bus.req_a ? HAND_A : IDLE;
      end
`ifdef Z_MUX_ARB_TURNAROUND_EN
      TURN: state_d = last_q ? (bus.req_a ? OWN_A : IDLE) : (bus.req_b ? OWN_B : IDLE);
`endif
      default: state_d = IDLE;
    endcase
    gnt_a_d = state_d == OWN_A;
    gnt_b_d = state_d == OWN_B;
    sel_d = gnt_a_d ? 1'b0 : gnt_b_d ? 1'b1 : sel_q;
    busy_d = gnt_a_d | gnt_b_d;
  end
  assign bus.sel = sel_q;
  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_z_mux_arbiter.sv
// tb_z_mux_arbiter: directed stimulus, ownership-level reference model and per-cycle comparison
module tb_z_mux_arbiter;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int m_owner = 0;
  int m_run = 0;
  int m_last = 2;
  logic m_sel = 1'b0;
  z_mux_arbiter_if bus ();
  z_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (.clk(clk), .reset_(reset_), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask
  // owner: 0 none, 1 A, 2 B; run counts cycles the current owner has held the path
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_owner = 0;
      m_run = 0;
      m_last = 2;
      m_sel = 1'b0;
    end else begin
      if (m_owner == 0) begin
        if (bus.req_a && (!bus.req_b || m_last == 2)) m_owner = 1;
        else if (bus.req_b) m_owner = 2;
        m_run = (m_owner != 0) ? 1 : 0;
      end else if (m_owner == 1) begin
        if (bus.done_a || !bus.req_a || (m_run >= MAX_HOLD && bus.req_b)) begin
          m_last = 1;
          m_owner = bus.req_b ? 2 : 0;
          m_run = (m_owner != 0) ? 1 : 0;
        end else m_run++;
      end else begin
        if (bus.done_b || !bus.req_b || (m_run >= MAX_HOLD && bus.req_a)) begin
          m_last = 2;
          m_owner = bus.req_a ? 1 : 0;
          m_run = (m_owner != 0) ? 1 : 0;
        end else m_run++;
      end
      if (m_owner == 1) m_sel = 1'b0;
      else if (m_owner == 2) m_sel = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (reset_) begin
      check("model_gnt_a", int'(bus.gnt_a), int'(m_owner == 1));
      check("model_gnt_b", int'(bus.gnt_b), int'(m_owner == 2));
      check("model_sel", int'(bus.sel), int'(m_sel));
      check("model_busy", int'(bus.busy), int'(m_owner != 0));
      check("onehot", int'(bus.gnt_a & bus.gnt_b), 0);
    end
  end
  initial begin
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.done_a = 1'b0;
    bus.done_b = 1'b0;
    #1;
    check("rst_sel", int'(bus.sel), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_gnt", int'({bus.gnt_a, bus.gnt_b}), 0);
    @(negedge clk) #1 reset_ = 1'b1;
    bus.req_b = 1'b1;
    @(negedge clk);
    check("b_granted", int'(bus.gnt_b), 1);
    check("b_sel", int'(bus.sel), 1);
    #2 reset_ = 1'b0;
    #1;
    check("midrst_sel", int'(bus.sel), 0);
    check("midrst_gnt_b", int'(bus.gnt_b), 0);
    check("midrst_busy", int'(bus.busy), 0);
    @(negedge clk) #1 reset_ = 1'b1;
    bus.req_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("contend_gnt_a", int'(bus.gnt_a), int'(((i - 1) / 4) % 2 == 0));
      check("contend_sel", int'(bus.sel), int'(((i - 1) / 4) % 2 == 1));
    end
    #1 bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    @(negedge clk);
    check("drop_busy", int'(bus.busy), 0);
    #1 bus.req_a = 1'b1;
    @(negedge clk);
    check("early_gnt_a", int'(bus.gnt_a), 1);
    @(negedge clk) #1 bus.done_a = 1'b1;
    bus.req_b = 1'b1;
    @(negedge clk);
    check("early_gnt_b", int'(bus.gnt_b), 1);
    check("early_sel", int'(bus.sel), 1);
    #1 bus.done_a = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_sel", int'(bus.sel), 1);
      check("idle_busy", int'(bus.busy), 0);
    end
    #1 bus.req_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("single_gnt_a", int'(bus.gnt_a), 1);
      check("single_sel", int'(bus.sel), 0);
    end
    check("hold_sat", int'(dut.cnt_q), 3);
    #1 bus.done_b = 1'b1;
    @(negedge clk);
    check("spurious_gnt_a", int'(bus.gnt_a), 1);
    #1 bus.done_b = 1'b0;
    bus.done_a = 1'b1;
    @(negedge clk);
    check("done_wins_gnt_a", int'(bus.gnt_a), 0);
    check("done_wins_busy", int'(bus.busy), 0);
    #1 bus.done_a = 1'b0;
    @(negedge clk);
    check("rearb_gnt_a", int'(bus.gnt_a), 1);
    #1 bus.req_a = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
